// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//   APB completer holding a DEPTH x 32-bit register file. Every transfer
//   spends WAIT_STATES access cycles with PREADY low before completing.
//   Accesses whose word index is outside the file complete with PSLVERR=1;
//   a write in that case leaves the file untouched, and a read returns 0.
//
// Ports
//   PCLK     in   1   clock, rising edge
//   PRESET   in   1   synchronous active-high reset
//   PSEL     in   1   slave select
//   PENABLE  in   1   access-phase indicator
//   PWRITE   in   1   1 = write, 0 = read
//   PADDR    in   32  byte address; [1:0] and [31] are ignored
//   PWDATA   in   32  write data
//   PREADY   out  1   transfer complete
//   PRDATA   out  32  read data, held between read transfers
//   PSLVERR  out  1   error response, meaningful only while PREADY=1
module apb_slave_regfile #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        err_q;
  logic [31:0] prdata_q;
  logic [31:0] mem [DEPTH];

  logic [28:0]   idx;
  logic [AW-1:0] word;
  logic          in_range;
  logic          setup;
  logic          unused_addr_bits;

  assign idx  = PADDR[30:2];
  assign word = idx[AW-1:0];
  // DEPTH is a power of two, so idx < DEPTH means no bit at or above AW is set.
  assign in_range = ~|idx[28:AW];
  assign setup    = PSEL && !PENABLE;
  assign unused_addr_bits = ^{PADDR[31], PADDR[1:0]};

  assign PREADY  = (state == ST_READY);
  assign PSLVERR = (state == ST_READY) && err_q;
  assign PRDATA  = prdata_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (setup) begin
      // A setup phase restarts the transfer from any state.
      err_q <= !in_range;
      if (!PWRITE) begin
        prdata_q <= in_range ? mem[word] : '0;
      end
      cnt   <= 4'(WAIT_STATES);
      state <= (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
    end else begin
      case (state)
        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= ST_READY;
            end
          end
        end
        ST_READY: begin
          if (PSEL && PENABLE) begin
            if (PWRITE && !err_q) begin
              mem[word] <= PWDATA;
            end
            state <= ST_IDLE;
          end else if (!PSEL) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile
//   Directed bench for apb_slave_regfile. Three instances (WAIT_STATES 0, 1
//   and 3) share the address/data/enable lines and each has its own PSEL.
module tb_apb_slave_regfile;

  logic        PCLK;
  logic        PRESET;
  logic [2:0]  psel;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        pready  [3];
  logic [31:0] prdata  [3];
  logic        pslverr [3];

  int unsigned vectors;
  int unsigned miscompares;

  logic [31:0] rd;
  logic        er;
  int unsigned w;

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(1)) u_ws1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
  );

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2])
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic bus_idle();
    psel    = '0;
    PENABLE = 1'b0;
  endtask

  // One full transfer on instance 'which'. Returns the data and error seen
  // in the PREADY cycle and the number of access cycles with PREADY low.
  // Leaves PSEL/PENABLE high so a following call runs back-to-back.
  task automatic xfer(input int unsigned which, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err,
                      output int unsigned waits);
    psel        = '0;
    psel[which] = 1'b1;
    PENABLE     = 1'b0;
    PWRITE      = wr;
    PADDR       = addr;
    PWDATA      = wdata;
    tick();
    PENABLE = 1'b1;
    waits   = 0;
    while (!pready[which] && waits < 20) begin
      tick();
      waits++;
    end
    if (!pready[which]) waits = 99;
    rdata = prdata[which];
    err   = pslverr[which];
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    PRESET  = 1'b1;
    psel    = '0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    tick();
    tick();
    PRESET = 1'b0;

    // Reset state
    check("rst_pready",  32'(pready[1]),  32'd0);
    check("rst_prdata",  prdata[1],       32'h0);
    check("rst_pslverr", 32'(pslverr[1]), 32'd0);
    check("rst_prdata3", prdata[2],       32'h0);

    // Read idx 3 after reset, one wait state
    xfer(1, 1'b0, 32'h0000_000C, 32'h0, rd, er, w);
    check("rd3_waits", 32'(w),  32'd1);
    check("rd3_data",  rd,      32'h0);
    check("rd3_err",   32'(er), 32'd0);

    // Write then back-to-back read of the same word
    xfer(1, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, rd, er, w);
    check("wr5_waits", 32'(w),  32'd1);
    check("wr5_err",   32'(er), 32'd0);
    xfer(1, 1'b0, 32'h0000_0014, 32'h0, rd, er, w);
    check("b2b_waits", 32'(w),  32'd1);
    check("b2b_data",  rd,      32'hDEAD_BEEF);
    bus_idle();
    tick();

    // Out-of-range write must not alias onto idx 0
    xfer(1, 1'b1, 32'h0000_0000, 32'h0000_1111, rd, er, w);
    xfer(1, 1'b1, 32'h0000_0040, 32'h1234_5678, rd, er, w);
    check("oor_wr_err",   32'(er), 32'd1);
    check("oor_wr_waits", 32'(w),  32'd1);
    xfer(1, 1'b0, 32'h0000_0000, 32'h0, rd, er, w);
    check("idx0_data", rd,      32'h0000_1111);
    check("idx0_err",  32'(er), 32'd0);
    xfer(1, 1'b0, 32'h0000_0040, 32'h0, rd, er, w);
    check("oor_rd_data", rd,      32'h0);
    check("oor_rd_err",  32'(er), 32'd1);
    bus_idle();
    tick();

    // Access phase without setup: no response, no write
    psel    = 3'b010;
    PENABLE = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 32'h0000_0000;
    PWDATA  = 32'hBAD0_BAD0;
    tick();
    check("noset_pready_a", 32'(pready[1]), 32'd0);
    tick();
    check("noset_pready_b", 32'(pready[1]), 32'd0);
    bus_idle();
    tick();
    xfer(1, 1'b0, 32'h0000_0000, 32'h0, rd, er, w);
    check("noset_idx0", rd, 32'h0000_1111);
    bus_idle();
    tick();

    // Wait-state count 0 vs 3, same data
    xfer(0, 1'b1, 32'h0000_0014, 32'hA5A5_A5A5, rd, er, w);
    xfer(2, 1'b1, 32'h0000_0014, 32'hA5A5_A5A5, rd, er, w);
    xfer(0, 1'b0, 32'h0000_0014, 32'h0, rd, er, w);
    check("ws0_waits", 32'(w), 32'd0);
    check("ws0_data",  rd,     32'hA5A5_A5A5);
    xfer(2, 1'b0, 32'h0000_0014, 32'h0, rd, er, w);
    check("ws3_waits", 32'(w), 32'd3);
    check("ws3_data",  rd,     32'hA5A5_A5A5);
    bus_idle();
    tick();

    // Abort after one wait cycle
    xfer(2, 1'b1, 32'h0000_0008, 32'h0000_2222, rd, er, w);
    psel    = 3'b100;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h0000_0008;
    PWDATA  = 32'hFFFF_FFFF;
    tick();
    PENABLE = 1'b1;
    tick();
    check("abort_wait_pready", 32'(pready[2]), 32'd0);
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_pready", 32'(pready[2]), 32'd0);
    end
    xfer(2, 1'b0, 32'h0000_0008, 32'h0, rd, er, w);
    check("abort_idx2", rd, 32'h0000_2222);
    bus_idle();
    tick();
    check("prdata_hold", prdata[2], 32'h0000_2222);

    // Reset during the wait phase of a write to idx 7
    psel    = 3'b100;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h0000_001C;
    PWDATA  = 32'h7777_7777;
    tick();
    PENABLE = 1'b1;
    tick();
    PRESET = 1'b1;
    tick();
    check("rstmid_pready", 32'(pready[2]), 32'd0);
    check("rstmid_prdata", prdata[2],      32'h0);
    PRESET = 1'b0;
    bus_idle();
    tick();
    xfer(2, 1'b0, 32'h0000_001C, 32'h0, rd, er, w);
    check("rstmid_idx7", rd, 32'h0);
    xfer(2, 1'b0, 32'h0000_0008, 32'h0, rd, er, w);
    check("rst_clears_idx2", rd, 32'h0);

    // Bit 31 of PADDR is ignored in decode
    xfer(1, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, rd, er, w);
    check("b31_wr_err", 32'(er), 32'd0);
    xfer(1, 1'b0, 32'h0000_0008, 32'h0, rd, er, w);
    check("b31_data", rd,      32'hCAFE_F00D);
    check("b31_err",  32'(er), 32'd0);
    bus_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
